// File: rtl/axis_frame_len_sched.sv
// axis_frame_len_sched
// Passive multi-port AXI-Stream frame-length monitor. Each port accumulates
// the byte count of its current frame (saturating at LEN_WIDTH). A completed
// length is parked in a one-deep per-port slot. All slots drain round-robin
// through one registered valid/ready report channel.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   monitor_axis_tkeep     per-port tkeep, port i at [i*KEEP_WIDTH +: KEEP_WIDTH]
//   monitor_axis_tvalid    per-port tvalid
//   monitor_axis_tready    per-port tready
//   monitor_axis_tlast     per-port tlast
//   frame_len              reported frame length in bytes
//   frame_len_port         source port of the reported frame
//   frame_len_valid        report valid
//   frame_len_ready        consumer accepts report
//   overflow               sticky per-port flag: a completed length was dropped
module axis_frame_len_sched #(
  parameter int unsigned PORTS       = 4,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned KEEP_ENABLE = (DATA_WIDTH > 8) ? 1 : 0,
  parameter int unsigned KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned LEN_WIDTH   = 16,
  parameter int unsigned PORT_WIDTH  = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS*KEEP_WIDTH-1:0] monitor_axis_tkeep,
  input  logic [PORTS-1:0]            monitor_axis_tvalid,
  input  logic [PORTS-1:0]            monitor_axis_tready,
  input  logic [PORTS-1:0]            monitor_axis_tlast,
  output logic [LEN_WIDTH-1:0]        frame_len,
  output logic [PORT_WIDTH-1:0]       frame_len_port,
  output logic                        frame_len_valid,
  input  logic                        frame_len_ready,
  output logic [PORTS-1:0]            overflow
);

  localparam int unsigned BYTE_W = $clog2(KEEP_WIDTH + 1);
  localparam int unsigned SUM_W  = LEN_WIDTH + BYTE_W;
  localparam logic [SUM_W-1:0] LEN_MAX = SUM_W'({LEN_WIDTH{1'b1}});

  logic [LEN_WIDTH-1:0]  cnt [PORTS];
  logic [LEN_WIDTH-1:0]  len [PORTS];
  logic [PORTS-1:0]      pend;
  logic [PORT_WIDTH-1:0] rr_start;

  logic [PORTS-1:0]      beat;
  logic [BYTE_W-1:0]     beat_bytes  [PORTS];
  logic [SUM_W-1:0]      beat_sum    [PORTS];
  logic [LEN_WIDTH-1:0]  beat_result [PORTS];

  logic                  arb_found;
  logic [PORT_WIDTH-1:0] arb_win;
  logic                  out_free;
  logic                  grant;

  // tkeep is only meaningful when byte counting via keep is enabled
  logic unused_keep;
  assign unused_keep = ^monitor_axis_tkeep;

  function automatic logic [BYTE_W-1:0] popcount(input logic [KEEP_WIDTH-1:0] k);
    logic [BYTE_W-1:0] c;
    c = '0;
    for (int j = 0; j < int'(KEEP_WIDTH); j++) begin
      c = c + BYTE_W'(k[j]);
    end
    return c;
  endfunction

  // Per-port beat detection and saturating running sum including this beat
  always_comb begin
    for (int i = 0; i < int'(PORTS); i++) begin
      beat[i] = monitor_axis_tvalid[i] && monitor_axis_tready[i];
      if (KEEP_ENABLE != 0) begin
        beat_bytes[i] = popcount(monitor_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH]);
      end else begin
        beat_bytes[i] = BYTE_W'(1);
      end
      beat_sum[i]    = SUM_W'(cnt[i]) + SUM_W'(beat_bytes[i]);
      beat_result[i] = (beat_sum[i] > LEN_MAX) ? '1 : beat_sum[i][LEN_WIDTH-1:0];
    end
  end

  // Round-robin pick: first pending port at or above rr_start, else lowest pending
  always_comb begin
    arb_found = 1'b0;
    arb_win   = '0;
    for (int i = 0; i < int'(PORTS); i++) begin
      if (!arb_found && pend[i] && (i >= int'(rr_start))) begin
        arb_found = 1'b1;
        arb_win   = PORT_WIDTH'(i);
      end
    end
    for (int i = 0; i < int'(PORTS); i++) begin
      if (!arb_found && pend[i]) begin
        arb_found = 1'b1;
        arb_win   = PORT_WIDTH'(i);
      end
    end
  end

  assign out_free = !frame_len_valid || frame_len_ready;
  assign grant    = out_free && arb_found;

  // Accumulators, holding slots, overflow flags and the report register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(PORTS); i++) begin
        cnt[i] <= '0;
        len[i] <= '0;
      end
      pend            <= '0;
      overflow        <= '0;
      rr_start        <= '0;
      frame_len       <= '0;
      frame_len_port  <= '0;
      frame_len_valid <= 1'b0;
    end else begin
      if (out_free) begin
        if (arb_found) begin
          frame_len       <= len[arb_win];
          frame_len_port  <= arb_win;
          frame_len_valid <= 1'b1;
          rr_start        <= (arb_win == PORT_WIDTH'(PORTS - 1)) ? '0 : arb_win + PORT_WIDTH'(1);
        end else begin
          frame_len_valid <= 1'b0;
        end
      end
      for (int i = 0; i < int'(PORTS); i++) begin
        if (grant && (arb_win == PORT_WIDTH'(i))) begin
          pend[i] <= 1'b0;
        end
        if (beat[i]) begin
          if (monitor_axis_tlast[i]) begin
            cnt[i] <= '0;
            // A slot drained this cycle can accept the new result immediately
            if (!pend[i] || (grant && (arb_win == PORT_WIDTH'(i)))) begin
              len[i]  <= beat_result[i];
              pend[i] <= 1'b1;
            end else begin
              overflow[i] <= 1'b1;
            end
          end else begin
            cnt[i] <= beat_result[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_frame_len_sched.sv
module tb_axis_frame_len_sched;
  localparam int P = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [P-1:0]   tvalid, tready, tlast;
  logic [P-1:0]   keep8;
  logic [4*P-1:0] keep32;
  logic           ready;

  logic [15:0] len8, len32;
  logic [1:0]  port8, port32;
  logic        v8, v32;
  logic [P-1:0] ovf8, ovf32;

  int tests = 0;
  int fails = 0;

  axis_frame_len_sched #(.PORTS(4), .DATA_WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .monitor_axis_tkeep(keep8), .monitor_axis_tvalid(tvalid),
    .monitor_axis_tready(tready), .monitor_axis_tlast(tlast),
    .frame_len(len8), .frame_len_port(port8), .frame_len_valid(v8),
    .frame_len_ready(ready), .overflow(ovf8)
  );

  axis_frame_len_sched #(.PORTS(4), .DATA_WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst),
    .monitor_axis_tkeep(keep32), .monitor_axis_tvalid(tvalid),
    .monitor_axis_tready(tready), .monitor_axis_tlast(tlast),
    .frame_len(len32), .frame_len_port(port32), .frame_len_valid(v32),
    .frame_len_ready(ready), .overflow(ovf32)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: per-port running byte count, one-deep slot, sticky drop flag,
  // and one report register served round-robin (index 0: 8-bit, 1: 32-bit).
  int m_acc  [2][P];
  bit m_has  [2][P];
  int m_hold [2][P];
  bit m_ovf  [2][P];
  int m_len  [2];
  int m_port [2];
  bit m_val  [2];
  int m_next [2];

  always @(posedge clk) begin
    int win, p, s, nb;
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < P; i++) begin
          m_acc[d][i] = 0; m_has[d][i] = 0; m_hold[d][i] = 0; m_ovf[d][i] = 0;
        end
        m_len[d] = 0; m_port[d] = 0; m_val[d] = 0; m_next[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (!m_val[d] || ready) begin
          win = -1;
          for (int k = 0; k < P; k++) begin
            p = (m_next[d] + k) % P;
            if (win < 0 && m_has[d][p]) win = p;
          end
          if (win >= 0) begin
            m_len[d] = m_hold[d][win];
            m_port[d] = win;
            m_val[d] = 1;
            m_has[d][win] = 0;
            m_next[d] = (win + 1) % P;
          end else begin
            m_val[d] = 0;
          end
        end
        for (int i = 0; i < P; i++) begin
          if (tvalid[i] && tready[i]) begin
            nb = (d == 0) ? 1 : $countones(keep32[i*4 +: 4]);
            s = m_acc[d][i] + nb;
            if (s > 65535) s = 65535;
            if (tlast[i]) begin
              m_acc[d][i] = 0;
              if (m_has[d][i]) m_ovf[d][i] = 1;
              else begin m_hold[d][i] = s; m_has[d][i] = 1; end
            end else begin
              m_acc[d][i] = s;
            end
          end
        end
      end
    end
  end

  task automatic cmp(input int d, input string tag, input logic v, input logic [15:0] l,
                     input logic [1:0] pt, input logic [P-1:0] o);
    int eo;
    eo = 0;
    for (int i = 0; i < P; i++) if (m_ovf[d][i]) eo |= (1 << i);
    check({tag, "_valid"}, int'(v), int'(m_val[d]));
    check({tag, "_overflow"}, int'(o), eo);
    if (m_val[d]) begin
      check({tag, "_len"}, int'(l), m_len[d]);
      check({tag, "_port"}, int'(pt), m_port[d]);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      cmp(0, "dut8", v8, len8, port8, ovf8);
      cmp(1, "dut32", v32, len32, port32, ovf32);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int port, input bit last);
    tvalid = P'(1) << port;
    tready = P'(1) << port;
    tlast  = last ? (P'(1) << port) : '0;
    tick();
    tvalid = '0; tready = '0; tlast = '0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Wait (bounded) for a report, then check it against literal values
  task automatic expect_report(input int port, input int l8, input int l32,
                               input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!v8 && n < budget);
    if (!v8) begin
      tests++;
      fails++;
      $display("FAIL %s: no report within %0d cycles, required port %0d len %0d", name, budget, port, l8);
    end else begin
      check({name, "_port8"}, int'(port8), port);
      check({name, "_len8"}, int'(len8), l8);
      check({name, "_valid32"}, int'(v32), 1);
      check({name, "_port32"}, int'(port32), port);
      check({name, "_len32"}, int'(len32), l32);
    end
  endtask

  initial begin
    rst = 1'b1;
    tvalid = '0; tready = '0; tlast = '0;
    keep8 = 4'b0101;
    keep32 = 16'h1111;
    ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("rst_valid8", int'(v8), 0);
    check("rst_len8", int'(len8), 0);
    check("rst_port8", int'(port8), 0);
    check("rst_ovf8", int'(ovf8), 0);
    check("rst_valid32", int'(v32), 0);
    check("rst_ovf32", int'(ovf32), 0);
    tick();
    rst = 1'b0;
    tick();

    // 3-beat frame on port 0: report exactly 2 cycles after tlast, for one cycle
    keep32[3:0] = 4'hF;
    beat(0, 0); beat(0, 0); beat(0, 1);
    @(negedge clk);
    check("t1_not_yet", int'(v8), 0);
    @(negedge clk);
    check("t1_valid", int'(v8), 1);
    check("t1_len8", int'(len8), 3);
    check("t1_port8", int'(port8), 0);
    check("t1_len32", int'(len32), 12);
    @(negedge clk);
    check("t1_one_cycle", int'(v8), 0);
    tick();

    // tkeep popcount: 0xF, 0xF, 0x3 on port 2
    keep32 = 16'h1111;
    keep32[11:8] = 4'hF;
    beat(2, 0); beat(2, 0);
    keep32[11:8] = 4'h3;
    beat(2, 1);
    expect_report(2, 3, 10, "t2", 5);
    keep32 = 16'h1111;
    tick();

    // Simultaneous single-beat frames on all ports, twice
    reset_dut();
    for (int r = 0; r < 2; r++) begin
      tvalid = '1; tready = '1; tlast = '1;
      tick();
      tvalid = '0; tready = '0; tlast = '0;
      expect_report(0, 1, 1, "t3_p0", 5);
      expect_report(1, 1, 1, "t3_p1", 1);
      expect_report(2, 1, 1, "t3_p2", 1);
      expect_report(3, 1, 1, "t3_p3", 1);
      tick(); tick();
    end

    // Backpressure: output busy with port 0, port 1 completes len 2 then len 5
    reset_dut();
    ready = 1'b0;
    beat(0, 1);
    tick(); tick();
    beat(1, 0); beat(1, 1);
    tick();
    beat(1, 0); beat(1, 0); beat(1, 0); beat(1, 0); beat(1, 1);
    tick();
    @(negedge clk);
    check("t4_ovf8", int'(ovf8), 2);
    check("t4_ovf32", int'(ovf32), 2);
    check("t4_hold_valid", int'(v8), 1);
    check("t4_hold_len", int'(len8), 1);
    check("t4_hold_port", int'(port8), 0);
    ready = 1'b1;
    expect_report(1, 2, 2, "t4_len2", 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t4_no_len5", int'(v8), 0);
    end
    tick();

    // Drain and new completion on port 0 in the same cycle
    reset_dut();
    ready = 1'b0;
    beat(0, 1);
    beat(0, 0); beat(0, 0); beat(0, 1);
    tick(); tick();
    beat(0, 0); beat(0, 0); beat(0, 0);
    ready = 1'b1;
    beat(0, 1);
    ready = 1'b0;
    @(negedge clk);
    check("t5_hold_valid", int'(v8), 1);
    check("t5_hold_len", int'(len8), 3);
    check("t5_ovf8", int'(ovf8), 0);
    ready = 1'b1;
    expect_report(0, 4, 4, "t5_len4", 1);
    check("t5_ovf8_end", int'(ovf8), 0);
    check("t5_ovf32_end", int'(ovf32), 0);
    tick();

    // Saturation: 65537 beats on port 3 (zero keep on the 32-bit instance)
    reset_dut();
    keep32[15:12] = 4'h0;
    tvalid = 4'b1000; tready = 4'b1000; tlast = '0;
    for (int k = 0; k < 65536; k++) tick();
    tlast = 4'b1000;
    tick();
    tvalid = '0; tready = '0; tlast = '0;
    expect_report(3, 65535, 0, "t6_sat", 5);
    tick();

    // Reset mid-frame on port 1, including a last beat during reset
    keep32 = 16'h1111;
    keep32[7:4] = 4'h3;
    beat(1, 0); beat(1, 0); beat(1, 0);
    rst = 1'b1;
    tvalid = 4'b0010; tready = 4'b0010; tlast = 4'b0010;
    tick();
    tvalid = '0; tready = '0; tlast = '0;
    rst = 1'b0;
    tick();
    beat(1, 0); beat(1, 1);
    expect_report(1, 2, 4, "t7_after_rst", 5);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
